// File: rtl/coram_channel_array.sv
// Bank of NUM_CH independent non-transparent FIFOs with occupancy,
// almost-full/empty margins and sticky overflow/underflow flags.
//
// Ports (channel i = bit i / slice i of every bus):
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   D, ENQ     enqueue data / request
//   Q, DEQ     registered dequeue data / request
//   FULL, ALM_FULL, EMPTY, ALM_EMPTY   status from the count register
//   COUNT      occupancy 0..DEPTH, (CORAM_ADDR_LEN+1) bits per channel
//   OVF, UDF   sticky ENQ-while-FULL / DEQ-while-EMPTY flags
//   ERR_CLR    clears OVF/UDF of the channel
module coram_channel_array #(
  parameter     CORAM_THREAD_NAME = "undefined",
  parameter int CORAM_THREAD_ID   = 0,
  parameter int CORAM_ID          = 0,
  parameter int CORAM_SUB_ID      = 0,
  parameter int NUM_CH            = 4,
  parameter int CORAM_ADDR_LEN    = 4,
  parameter int CORAM_DATA_WIDTH  = 32,
  parameter int ALM_FULL_MARGIN   = 1,
  parameter int ALM_EMPTY_MARGIN  = 1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_CH*CORAM_DATA_WIDTH-1:0]   D,
  input  logic [NUM_CH-1:0]                    ENQ,
  output logic [NUM_CH-1:0]                    FULL,
  output logic [NUM_CH-1:0]                    ALM_FULL,
  output logic [NUM_CH*CORAM_DATA_WIDTH-1:0]   Q,
  input  logic [NUM_CH-1:0]                    DEQ,
  output logic [NUM_CH-1:0]                    EMPTY,
  output logic [NUM_CH-1:0]                    ALM_EMPTY,
  output logic [NUM_CH*(CORAM_ADDR_LEN+1)-1:0] COUNT,
  output logic [NUM_CH-1:0]                    OVF,
  output logic [NUM_CH-1:0]                    UDF,
  input  logic [NUM_CH-1:0]                    ERR_CLR
);

  localparam int AW    = CORAM_ADDR_LEN;
  localparam int W     = CORAM_DATA_WIDTH;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF_TH = CW'(DEPTH - ALM_FULL_MARGIN);
  localparam logic [CW-1:0] C_AE_TH = CW'(ALM_EMPTY_MARGIN);

  if (NUM_CH < 1) begin : g_chk_nch
    $error("NUM_CH must be >= 1");
  end
  if (ALM_FULL_MARGIN < 0 || ALM_FULL_MARGIN >= DEPTH) begin : g_chk_af
    $error("ALM_FULL_MARGIN out of range 0..DEPTH-1");
  end
  if (ALM_EMPTY_MARGIN < 0 || ALM_EMPTY_MARGIN >= DEPTH) begin : g_chk_ae
    $error("ALM_EMPTY_MARGIN out of range 0..DEPTH-1");
  end
  if (CORAM_THREAD_ID < 0 || CORAM_ID < 0 || CORAM_SUB_ID < 0)
  begin : g_chk_id
    $error("CoRAM ids must be non-negative");
  end
  if (CORAM_THREAD_NAME == "") begin : g_chk_name
    $error("CORAM_THREAD_NAME must not be empty");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_q;
    logic          r_ovf;
    logic          r_udf;
    logic [W-1:0]  r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_enq_ok;
    logic w_deq_ok;
    logic w_ovf_ev;
    logic w_udf_ev;

    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_enq_ok = ENQ[i] & ~w_full;
    assign w_deq_ok = DEQ[i] & ~w_empty;
    assign w_ovf_ev = ENQ[i] & w_full;
    assign w_udf_ev = DEQ[i] & w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
      if (!RST && w_enq_ok)
        r_mem[r_wr_ptr] <= D[i*W +: W];
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_q      <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (w_enq_ok)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_deq_ok) begin
          r_q      <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_enq_ok && !w_deq_ok)
          r_count <= r_count + 1'b1;
        else if (w_deq_ok && !w_enq_ok)
          r_count <= r_count - 1'b1;
        // A new event in the ERR_CLR cycle keeps the flag set.
        r_ovf <= w_ovf_ev | (r_ovf & ~ERR_CLR[i]);
        r_udf <= w_udf_ev | (r_udf & ~ERR_CLR[i]);
      end
    end

    assign FULL[i]            = w_full;
    assign EMPTY[i]           = w_empty;
    assign ALM_FULL[i]        = (r_count >= C_AF_TH);
    assign ALM_EMPTY[i]       = (r_count <= C_AE_TH);
    assign COUNT[i*CW +: CW]  = r_count;
    assign Q[i*W +: W]        = r_q;
    assign OVF[i]             = r_ovf;
    assign UDF[i]             = r_udf;
  end

endmodule

// File: tb/tb_coram_channel_array.sv
// Bench for coram_channel_array: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_coram_channel_array;

  localparam int NCH = 2;
  localparam int AW  = 2;
  localparam int W   = 8;
  localparam int DEP = 4;

  logic              CLK;
  logic              RST;
  logic [NCH*W-1:0]  D;
  logic [NCH-1:0]    ENQ;
  logic [NCH-1:0]    FULL;
  logic [NCH-1:0]    ALM_FULL;
  logic [NCH*W-1:0]  Q;
  logic [NCH-1:0]    DEQ;
  logic [NCH-1:0]    EMPTY;
  logic [NCH-1:0]    ALM_EMPTY;
  logic [NCH*(AW+1)-1:0] COUNT;
  logic [NCH-1:0]    OVF;
  logic [NCH-1:0]    UDF;
  logic [NCH-1:0]    ERR_CLR;

  coram_channel_array #(
    .CORAM_THREAD_NAME("tb"),
    .NUM_CH(NCH),
    .CORAM_ADDR_LEN(AW),
    .CORAM_DATA_WIDTH(W),
    .ALM_FULL_MARGIN(1),
    .ALM_EMPTY_MARGIN(1)
  ) dut (
    .CLK(CLK), .RST(RST), .D(D), .ENQ(ENQ), .FULL(FULL),
    .ALM_FULL(ALM_FULL), .Q(Q), .DEQ(DEQ), .EMPTY(EMPTY),
    .ALM_EMPTY(ALM_EMPTY), .COUNT(COUNT), .OVF(OVF), .UDF(UDF),
    .ERR_CLR(ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  bit [7:0] mq [NCH][$];
  bit [7:0] m_q   [NCH];
  bit       m_ovf [NCH];
  bit       m_udf [NCH];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit [1:0] enq,
                            input bit [1:0] deq, input bit [7:0] d0,
                            input bit [7:0] d1, input bit [1:0] clr);
    for (int c = 0; c < NCH; c++) begin
      int  sz;
      bit  full, empty;
      if (rst) begin
        mq[c].delete();
        m_q[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
      end else begin
        sz    = mq[c].size();
        full  = (sz == DEP);
        empty = (sz == 0);
        m_ovf[c] = (enq[c] && full) || (m_ovf[c] && !clr[c]);
        m_udf[c] = (deq[c] && empty) || (m_udf[c] && !clr[c]);
        if (deq[c] && !empty) m_q[c] = mq[c].pop_front();
        if (enq[c] && !full) mq[c].push_back(c == 0 ? d0 : d1);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++) begin
      int sz;
      sz = mq[c].size();
      chk({tag, "/count"}, 32'(COUNT[c*(AW+1) +: AW+1]), 32'(sz));
      chk({tag, "/empty"}, 32'(EMPTY[c]), 32'(sz == 0));
      chk({tag, "/full"},  32'(FULL[c]),  32'(sz == DEP));
      chk({tag, "/afull"}, 32'(ALM_FULL[c]), 32'(sz >= DEP - 1));
      chk({tag, "/aempty"}, 32'(ALM_EMPTY[c]), 32'(sz <= 1));
      chk({tag, "/q"},     32'(Q[c*W +: W]), 32'(m_q[c]));
      chk({tag, "/ovf"},   32'(OVF[c]), 32'(m_ovf[c]));
      chk({tag, "/udf"},   32'(UDF[c]), 32'(m_udf[c]));
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit [1:0] enq,
                      input bit [1:0] deq, input bit [7:0] d0,
                      input bit [7:0] d1, input bit [1:0] clr);
    @(negedge CLK);
    RST = rst; ENQ = enq; DEQ = deq; D = {d1, d0}; ERR_CLR = clr;
    @(posedge CLK);
    model_edge(rst, enq, deq, d0, d1, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit [7:0] v;
    RST = 1'b1; ENQ = '0; DEQ = '0; D = '0; ERR_CLR = '0;

    step("reset", 1, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(EMPTY), 32'h3);
    chk("rst_aempty", 32'(ALM_EMPTY), 32'h3);
    chk("rst_full", 32'(FULL), 32'h0);
    chk("rst_count", 32'(COUNT), 32'h0);

    step("fill", 0, 2'b01, 0, 8'h11, 0, 0);
    step("fill", 0, 2'b01, 0, 8'h22, 0, 0);
    step("fill", 0, 2'b01, 0, 8'h33, 0, 0);
    chk("fill_afull3", 32'(ALM_FULL[0]), 32'h1);
    chk("fill_nfull3", 32'(FULL[0]), 32'h0);
    step("fill", 0, 2'b01, 0, 8'h44, 0, 0);
    chk("fill_full4", 32'(FULL[0]), 32'h1);
    chk("fill_ch1_empty", 32'(EMPTY[1]), 32'h1);

    step("drain", 0, 0, 2'b01, 0, 0, 0);
    chk("drain_q1", 32'(Q[7:0]), 32'h11);
    step("drain", 0, 0, 2'b01, 0, 0, 0);
    chk("drain_q2", 32'(Q[7:0]), 32'h22);
    step("drain", 0, 0, 2'b01, 0, 0, 0);
    chk("drain_q3", 32'(Q[7:0]), 32'h33);
    step("drain", 0, 0, 2'b01, 0, 0, 0);
    chk("drain_q4", 32'(Q[7:0]), 32'h44);
    step("drain_hold", 0, 0, 0, 0, 0, 0);
    chk("drain_hold_q", 32'(Q[7:0]), 32'h44);
    chk("drain_empty", 32'(EMPTY[0]), 32'h1);

    for (int k = 0; k < 4; k++)
      step("refill", 0, 2'b01, 0, 8'hA1 + 8'(k), 0, 0);
    step("full_enq_deq", 0, 2'b01, 2'b01, 8'h55, 0, 0);
    chk("fed_q", 32'(Q[7:0]), 32'hA1);
    chk("fed_count", 32'(COUNT[AW:0]), 32'd3);
    chk("fed_ovf", 32'(OVF[0]), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step("fed_drain", 0, 0, 2'b01, 0, 0, 0);
      chk("fed_no55", 32'(Q[7:0] == 8'h55), 32'h0);
    end

    step("empty_enq_deq", 0, 2'b10, 2'b10, 0, 8'h66, 0);
    chk("eed_udf", 32'(UDF[1]), 32'h1);
    chk("eed_count", 32'(COUNT[2*AW+1:AW+1]), 32'd1);
    chk("eed_q", 32'(Q[15:8]), 32'h00);
    step("eed_deq", 0, 0, 2'b10, 0, 0, 0);
    chk("eed_q66", 32'(Q[15:8]), 32'h66);

    step("wrap_pre", 0, 2'b01, 0, 8'hC0, 0, 0);
    step("wrap_pre", 0, 2'b01, 0, 8'hC1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step("wrap", 0, 2'b01, 2'b01, 8'hC2 + 8'(k), 0, 0);
      chk("wrap_q", 32'(Q[7:0]), 32'(8'hC0 + 8'(k)));
      chk("wrap_count", 32'(COUNT[AW:0]), 32'd2);
    end

    step("clr", 0, 0, 0, 0, 0, 2'b11);
    chk("clr_ovf", 32'(OVF), 32'h0);
    chk("clr_udf", 32'(UDF), 32'h0);

    step("top", 0, 2'b01, 0, 8'hD0, 0, 0);
    step("top", 0, 2'b01, 0, 8'hD1, 0, 0);
    step("clr_vs_ovf", 0, 2'b01, 0, 8'hD2, 0, 2'b01);
    chk("clr_vs_ovf_flag", 32'(OVF[0]), 32'h1);
    step("to3", 0, 0, 2'b01, 0, 0, 0);
    step("mid_rst", 1, 2'b11, 2'b11, 8'hEE, 8'hEE, 0);
    chk("mrst_empty", 32'(EMPTY), 32'h3);
    chk("mrst_count", 32'(COUNT), 32'h0);
    chk("mrst_q", 32'(Q), 32'h0);
    chk("mrst_flags", 32'({OVF, UDF}), 32'h0);

    for (int k = 0; k < 400; k++) begin
      bit r;
      r = ($urandom_range(0, 59) == 0);
      v = 8'($urandom);
      step("rand", r, 2'($urandom), 2'($urandom), v, 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
